booth_digit_streamer: RTL and testbench
=======================================

BOOTH_DIGIT_STREAMER -- requirements
Module: booth_digit_streamer

Interface
REQ-001 The block SHALL have parameter b_len, default 64, giving the multiplier operand width; it must be even and at least 4.
REQ-002 The block SHALL have parameter idx_len, default 6, giving the digit-index width; it must satisfy 2^idx_len >= b_len/2+1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port B, input, b_len bits: multiplier operand, sampled on an accepted input.
REQ-006 Port in_valid, input, 1 bit: the B offer is valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept B.
REQ-008 Port abort, input, 1 bit: synchronous cancel of the current operand.
REQ-009 Port neg, output, 1 bit: the current digit is negative.
REQ-010 Port zero, output, 1 bit: the current digit has magnitude 0.
REQ-011 Port one, output, 1 bit: the current digit has magnitude 1.
REQ-012 Port two, output, 1 bit: the current digit has magnitude 2.
REQ-013 Port idx, output, idx_len bits: index of the current radix-4 digit, starting at 0.
REQ-014 Port last, output, 1 bit: the current digit is the final digit of the operand.
REQ-015 Port out_valid, output, 1 bit: the digit outputs are valid.
REQ-016 Port out_ready, input, 1 bit: the consumer accepts the digit.
REQ-017 Port busy, output, 1 bit: an operand is in progress.

Function
REQ-018 The block SHALL be a radix-4 Booth recoder that emits one digit per output handshake as {neg, zero, one, two}, directly usable as the select inputs of the team's partial-product generator.
REQ-019 Digit i SHALL be recoded from the triplet (b[2i+1], b[2i], b[2i-1]), with b[-1]=0, as follows:
- 000 and 111: zero
- 001 and 010: +1
- 011: +2
- 100: -2
- 101 and 110: -1
REQ-020 Exactly one of zero, one or two SHALL be 1 whenever out_valid=1, and neg SHALL be 0 whenever zero=1.
REQ-021 Digit count N SHALL be b_len/2+1, with B zero-extended by 2 bits (unsigned B); the configuration option changes this (REQ-035).
REQ-022 The state machine SHALL have two states, IDLE and RUN.
- IDLE: in_ready=1, out_valid=0, busy=0.
- RUN: in_ready=0, out_valid=1, busy=1.
REQ-023 In IDLE, a cycle with in_valid=1 SHALL latch B and move to RUN; the next cycle SHALL present digit idx=0.
REQ-024 In RUN, the digit SHALL advance (idx+1, operand shifted by 2) only on a cycle with out_valid=1 and out_ready=1.
REQ-025 While out_ready=0, neg, zero, one, two, idx and last SHALL hold stable.
REQ-026 last SHALL be 1 exactly when idx=N-1.
REQ-027 A handshake on the last digit SHALL return the block to IDLE, with in_ready=1 the next cycle; minimum throughput is N+1 cycles per operand.
REQ-028 The block SHALL NOT accept a new input in the same cycle as a last-digit handshake.
REQ-029 abort=1 in RUN SHALL force IDLE on the next cycle regardless of out_ready, and no further digits SHALL be emitted for that operand.
REQ-030 abort=1 in IDLE SHALL block acceptance of B in that cycle.
REQ-031 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-032 rst_n=0 at a rising clk edge SHALL force the state to IDLE, including mid-operation; the pending operand is discarded.
REQ-033 Reset SHALL drive these output values:
- in_ready=1 (asserted from the first cycle after reset)
- out_valid=0, busy=0, last=0, idx=0
- zero=1, neg=0, one=0, two=0
REQ-034 During reset, in_valid and out_ready SHALL be ignored.

Configuration
REQ-035 The macro BOOTH_SIGNED_EN SHALL select the operand interpretation.
- Defined: B is two's-complement signed, N=b_len/2, and the last digit is idx=b_len/2-1.
- Undefined: B is unsigned, zero-extended, and N=b_len/2+1.

Verification
REQ-036 Unsigned, B=0 -> 33 digits, all zero=1, neg=0; last=1 only at idx=32; in_ready=1 on the following cycle.
REQ-037 Unsigned, B=3 -> idx0: neg=1, one=1; idx1: one=1; idx2..32: zero=1.
REQ-038 Unsigned, B=64'hFFFF_FFFF_FFFF_FFFF -> idx0: neg=1, one=1; idx1..31: zero=1; idx32: one=1, last=1 (value 4^32-1).
REQ-039 BOOTH_SIGNED_EN, B=2 -> idx0: neg=1, two=1; idx1: one=1; idx2..31: zero=1; last at idx=31. With B=all-ones -> idx0 is -1 and all remaining digits are zero.
REQ-040 Stall, then abort: out_ready=0 for 5 cycles at idx=5 -> outputs hold idx=5 unchanged, and resume at idx=6 after release. Then abort=1 at idx=10 -> next cycle out_valid=0, in_ready=1.
REQ-041 Reset mid-operation: rst_n=0 for 1 cycle at idx=10 -> next cycle out_valid=0, busy=0, in_ready=1. A new B is then accepted and starts at idx=0.

Source files
------------

// File: rtl/booth_digit_streamer.sv
// rtl/booth_digit_streamer.sv - radix-4 Booth recoder streaming one digit per handshake
//
// Purpose: accepts a multiplier operand B and emits its radix-4 Booth digits,
// least significant first, as {neg, zero, one, two} partial-product selects.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst_n      - synchronous active-low reset
//   B          - multiplier operand, sampled when accepted in IDLE
//   in_valid   - B offer is valid
//   in_ready   - block can accept B (IDLE)
//   abort      - cancel current operand / block acceptance
//   neg/zero/one/two - current digit sign and one-hot magnitude
//   idx        - index of the current digit
//   last       - current digit is the final digit
//   out_valid  - digit outputs valid (RUN)
//   out_ready  - consumer accepts the digit
//   busy       - an operand is in progress
//
// Configuration macro: BOOTH_SIGNED_EN
//   defined   - B is two's-complement, b_len/2 digits
//   undefined - B is unsigned (zero-extended by 2 bits), b_len/2+1 digits
//
// Parameter constraints: b_len even and >= 4; 2**idx_len >= b_len/2+1.

module booth_digit_streamer #(
    parameter int b_len   = 64,
    parameter int idx_len = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [b_len-1:0]   B,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               abort,
    output logic               neg,
    output logic               zero,
    output logic               one,
    output logic               two,
    output logic [idx_len-1:0] idx,
    output logic               last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

`ifdef BOOTH_SIGNED_EN
    // Signed: the top triplet already carries the sign, no extension needed.
    localparam int N_DIG = b_len / 2;
    localparam int SH_W  = b_len;
`else
    // Unsigned: two zero bits on top make the final digit non-negative.
    localparam int N_DIG = b_len / 2 + 1;
    localparam int SH_W  = b_len + 2;
`endif

    localparam logic [idx_len-1:0] PRE_LAST = idx_len'(N_DIG - 2);
    localparam logic [3:0]         DIG_ZERO = 4'b0100;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    sh_q, sh_d;       // remaining operand bits, next pair at [1:0]
    logic               prev_q, prev_d;   // b[2i-1] for the next digit
    logic [3:0]         dig_q, dig_d;     // {neg, zero, one, two}
    logic [idx_len-1:0] idx_q, idx_d;
    logic               last_q, last_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    // Triplet {b[2i+1], b[2i], b[2i-1]} to {neg, zero, one, two}.
    function automatic logic [3:0] recode(input logic [2:0] t);
        logic [3:0] r;
        case (t)
            3'b001, 3'b010: r = 4'b0010;  // +1
            3'b011:         r = 4'b0001;  // +2
            3'b100:         r = 4'b1001;  // -2
            3'b101, 3'b110: r = 4'b1010;  // -1
            default:        r = DIG_ZERO; // 000, 111
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        prev_d  = prev_q;
        dig_d   = dig_q;
        idx_d   = idx_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    // Digit 0 is computed at acceptance so it appears the next cycle.
                    state_d = RUN;
                    dig_d   = recode({B[1:0], 1'b0});
                    sh_d    = SH_W'(B) >> 2;
                    prev_d  = B[1];
                    idx_d   = '0;
                    last_d  = 1'b0;
                end
            end
            RUN: begin
                if (abort || (out_ready && last_q)) begin
                    state_d = IDLE;
                    dig_d   = DIG_ZERO;
                    sh_d    = '0;
                    prev_d  = 1'b0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end else if (out_ready) begin
                    dig_d  = recode({sh_q[1:0], prev_q});
                    sh_d   = sh_q >> 2;
                    prev_d = sh_q[1];
                    idx_d  = idx_q + 1'b1;
                    last_d = (idx_q == PRE_LAST);
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered from the next state so no input
        // reaches an output combinationally.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RUN);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            prev_q      <= 1'b0;
            dig_q       <= DIG_ZERO;
            idx_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            prev_q      <= prev_d;
            dig_q       <= dig_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign neg       = dig_q[3];
    assign zero      = dig_q[2];
    assign one       = dig_q[1];
    assign two       = dig_q[0];
    assign idx       = idx_q;
    assign last      = last_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_booth_digit_streamer.sv
// tb/tb_booth_digit_streamer.sv - directed self-checking bench for booth_digit_streamer

module tb_booth_digit_streamer;

`ifdef BOOTH_SIGNED_EN
    localparam int N_DIG = 32;
`else
    localparam int N_DIG = 33;
`endif

    localparam logic [3:0] ZR = 4'b0100;
    localparam logic [3:0] P1 = 4'b0010;
    localparam logic [3:0] M1 = 4'b1010;
    localparam logic [3:0] P2 = 4'b0001;
    localparam logic [3:0] M2 = 4'b1001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] B;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        neg, zero, one, two;
    logic [5:0]  idx;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    booth_digit_streamer #(.b_len(64), .idx_len(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .neg       (neg),
        .zero      (zero),
        .one       (one),
        .two       (two),
        .idx       (idx),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Operand vectors and their hand-derived digit tables.
    function automatic logic [63:0] vec(input int v);
        case (v)
            0: return 64'h0;
`ifdef BOOTH_SIGNED_EN
            1: return 64'h2;
`else
            1: return 64'h3;
`endif
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return 64'h5;
        endcase
    endfunction

    function automatic logic [3:0] exp_dig(input int v, input int i);
        logic [3:0] d;
        d = ZR;
        case (v)
`ifdef BOOTH_SIGNED_EN
            1: if (i == 0) d = M2; else if (i == 1) d = P1;
            2: if (i == 0) d = M1;
            3: if (i == 31) d = M2;
`else
            1: if (i == 0) d = M1; else if (i == 1) d = P1;
            2: if (i == 0) d = M1; else if (i == 32) d = P1;
            3: if (i == 31) d = M2; else if (i == 32) d = P1;
`endif
            4: if (i == 0 || i == 1) d = P1;
            default: d = ZR;
        endcase
        return d;
    endfunction

    function automatic logic [63:0] mk(input logic ir, input logic bz, input logic ov,
                                       input logic lst, input logic [5:0] ix, input logic [3:0] dg);
        return 64'({ir, bz, ov, lst, ix, dg});
    endfunction

    function automatic logic [63:0] obs();
        return 64'({in_ready, busy, out_valid, last, idx, neg, zero, one, two});
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] b);
        B        = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Check digits from..to while handshaking each one.
    task automatic walk(input int v, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            check($sformatf("v%0d_i%0d", v, i), obs(),
                  mk(1'b0, 1'b1, 1'b1, i == N_DIG - 1, 6'(i), exp_dig(v, i)));
            out_ready = 1'b1;
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, obs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, ZR));
    endtask

    initial begin
        rst_n     = 1'b0;
        B         = 64'hDEAD_BEEF_0000_0001;
        in_valid  = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check_idle("reset_state");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        check_idle("idle_after_reset");

        // Full operands, all handshakes immediate.
        for (int v = 0; v < 5; v++) begin
            load(vec(v));
            walk(v, 0, N_DIG - 1);
            check_idle($sformatf("v%0d_done", v));
        end

        // Abort in IDLE blocks acceptance.
        abort    = 1'b1;
        B        = vec(4);
        in_valid = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_idle");

        // in_valid held across the last handshake is not taken that cycle.
        load(vec(4));
        walk(4, 0, N_DIG - 2);
        in_valid = 1'b1;
        walk(4, N_DIG - 1, N_DIG - 1);
        check_idle("no_accept_on_last");
        step();
        in_valid = 1'b0;
        check("accept_after_last", obs(), mk(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, exp_dig(4, 0)));
        walk(4, 0, N_DIG - 1);
        check_idle("v4_again_done");

        // Stall at idx 5, resume, then abort at idx 10.
        load(vec(1));
        walk(1, 0, 4);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("stall_%0d", k), obs(), mk(1'b0, 1'b1, 1'b1, 1'b0, 6'd5, exp_dig(1, 5)));
        end
        walk(1, 5, 9);
        check("at_idx10", obs(), mk(1'b0, 1'b1, 1'b1, 1'b0, 6'd10, exp_dig(1, 10)));
        abort     = 1'b1;
        out_ready = 1'b0;
        step();
        abort     = 1'b0;
        out_ready = 1'b1;
        check_idle("abort_run");

        // Reset mid-operation, then a fresh operand starts at idx 0.
        load(vec(3));
        walk(3, 0, 9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("reset_mid_op");
        load(vec(4));
        walk(4, 0, N_DIG - 1);
        check_idle("after_reset_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
